// File: rtl/busyctr_prog.sv
// ---------------------------------------------------------------------------
// busyctr_prog
//   Programmable busy/timeout counter. An accepted start loads a run-time
//   length N. The block then reports busy for exactly N cycles and pulses
//   done for one cycle when the run expires. The current remaining count is
//   visible on o_count. Hold pauses the count, abort cancels the run, and two
//   compile-time options add retrigger and periodic auto-reload.
//
// Parameters
//   BW            counter and load width in bits (2..32)
//   OPT_RETRIGGER 1: a start while busy reloads the counter; 0: it is ignored
//   OPT_PERIODIC  1: i_periodic is honoured; 0: i_periodic is treated as 0
//
// Ports
//   i_clk       system clock, all logic on the rising edge
//   i_reset     synchronous active-high reset
//   i_start     start request, sampled every cycle
//   i_load      length N, sampled with an accepted start
//   i_periodic  auto-reload request, sampled with an accepted start
//   i_hold      freezes the count while high
//   i_abort     cancels the current run without a done pulse
//   o_busy      counter != 0
//   o_done      single-cycle expiry pulse (registered)
//   o_count     remaining cycles (current counter value)
// ---------------------------------------------------------------------------
module busyctr_prog #(
    parameter int unsigned BW            = 16,
    parameter bit          OPT_RETRIGGER = 1'b0,
    parameter bit          OPT_PERIODIC  = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [BW-1:0] i_load,
    input  logic          i_periodic,
    input  logic          i_hold,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic [BW-1:0] o_count
);

    localparam logic [BW-1:0] ONE = BW'(1);

    logic [BW-1:0] count_q, count_d;
    logic [BW-1:0] len_q,   len_d;
    logic          per_q,   per_d;
    logic          done_q,  done_d;

    logic          busy;
    logic          start_acc;

    assign busy = (count_q != '0);

    // A zero length is never accepted; while busy a start only counts when
    // retriggering is enabled.
    assign start_acc = i_start && (i_load != '0) && (!busy || OPT_RETRIGGER);

    // Next-state logic, priority: abort > accepted start > hold > decrement.
    // Reset is applied in the register process and overrides all of these.
    always_comb begin
        count_d = count_q;
        len_d   = len_q;
        per_d   = per_q;
        done_d  = 1'b0;

        if (i_abort) begin
            count_d = '0;
            per_d   = 1'b0;
        end else if (start_acc) begin
            // A retrigger in the expiry cycle wins: the old run never reports done.
            count_d = i_load;
            len_d   = i_load;
            per_d   = i_periodic && OPT_PERIODIC;
        end else if (i_hold) begin
            // Everything frozen; done is a pulse so it still drops.
            count_d = count_q;
        end else if (busy) begin
            if (count_q == ONE) begin
                done_d  = 1'b1;
                // Periodic runs reload instead of passing through zero, so
                // busy stays high without a gap.
                count_d = per_q ? len_q : '0;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
            len_q   <= '0;
            per_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
            per_q   <= per_d;
            done_q  <= done_d;
        end
    end

    assign o_busy  = busy;
    assign o_done  = done_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_busyctr_prog.sv
module tb_busyctr_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] load;
    logic        periodic;
    logic        hold;
    logic        abort;

    // dut0: BW=16, no retrigger, periodic enabled
    logic        busy0, done0;
    logic [15:0] cnt0;
    // dut1: BW=16, retrigger, periodic enabled
    logic        busy1, done1;
    logic [15:0] cnt1;
    // dut2: BW=4, retrigger, periodic disabled
    logic        busy2, done2;
    logic [3:0]  cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    busyctr_prog #(.BW(16), .OPT_RETRIGGER(1'b0), .OPT_PERIODIC(1'b1)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_load(load),
        .i_periodic(periodic), .i_hold(hold), .i_abort(abort),
        .o_busy(busy0), .o_done(done0), .o_count(cnt0)
    );

    busyctr_prog #(.BW(16), .OPT_RETRIGGER(1'b1), .OPT_PERIODIC(1'b1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_load(load),
        .i_periodic(periodic), .i_hold(hold), .i_abort(abort),
        .o_busy(busy1), .o_done(done1), .o_count(cnt1)
    );

    busyctr_prog #(.BW(4), .OPT_RETRIGGER(1'b1), .OPT_PERIODIC(1'b0)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_load(load[3:0]),
        .i_periodic(periodic), .i_hold(hold), .i_abort(abort),
        .o_busy(busy2), .o_done(done2), .o_count(cnt2)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; load = 0; periodic = 0; hold = 0; abort = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({busy0, done0, cnt0} !== 18'd0) begin
            n_err++; $display("FAIL reset_dut0: got busy=%0b done=%0b count=%0d, want 0/0/0", busy0, done0, cnt0);
        end
        n_cmp++;
        if ({busy1, done1, cnt1} !== 18'd0) begin
            n_err++; $display("FAIL reset_dut1: got busy=%0b done=%0b count=%0d, want 0/0/0", busy1, done1, cnt1);
        end
        n_cmp++;
        if ({busy2, done2, cnt2} !== 6'd0) begin
            n_err++; $display("FAIL reset_dut2: got busy=%0b done=%0b count=%0d, want 0/0/0", busy2, done2, cnt2);
        end
    endtask

    task automatic test_basic();
        do_reset();
        repeat (3) tick();
        start = 1; load = 5;
        tick();
        start = 0; load = 0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (busy0 !== 1'b1 || done0 !== 1'b0 || cnt0 !== 16'(5 - k)) begin
                n_err++; $display("FAIL basic_run[%0d]: got busy=%0b done=%0b count=%0d, want 1/0/%0d", k, busy0, done0, cnt0, 5 - k);
            end
            tick();
        end
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b1 || cnt0 !== 16'd0) begin
            n_err++; $display("FAIL basic_expiry: got busy=%0b done=%0b count=%0d, want 0/1/0", busy0, done0, cnt0);
        end
        tick();
        n_cmp++;
        if (done0 !== 1'b0) begin
            n_err++; $display("FAIL basic_done_single: got done=%0b, want 0", done0);
        end
    endtask

    task automatic test_zero_load();
        do_reset();
        start = 1; load = 0;
        tick();
        start = 0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (busy0 !== 1'b0 || done0 !== 1'b0) begin
                n_err++; $display("FAIL zero_load[%0d]: got busy=%0b done=%0b, want 0/0", k, busy0, done0);
            end
            tick();
        end
        start = 1; load = 1;
        tick();
        start = 0; load = 0;
        n_cmp++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || cnt0 !== 16'd1) begin
            n_err++; $display("FAIL load1_busy: got busy=%0b done=%0b count=%0d, want 1/0/1", busy0, done0, cnt0);
        end
        tick();
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b1) begin
            n_err++; $display("FAIL load1_done: got busy=%0b done=%0b, want 0/1", busy0, done0);
        end
    endtask

    task automatic test_periodic_abort();
        do_reset();
        start = 1; load = 4; periodic = 1;
        tick();
        start = 0; load = 0; periodic = 0;
        for (int k = 0; k < 13; k++) begin
            n_cmp++;
            if (busy0 !== 1'b1 || cnt0 !== 16'(4 - (k % 4)) || done0 !== (k >= 4 && k % 4 == 0)) begin
                n_err++; $display("FAIL periodic[%0d]: got busy=%0b done=%0b count=%0d, want 1/%0b/%0d",
                                  k, busy0, done0, cnt0, (k >= 4 && k % 4 == 0), 4 - (k % 4));
            end
            if (k == 4) begin
                n_cmp++;
                if (busy2 !== 1'b0 || done2 !== 1'b1) begin
                    n_err++; $display("FAIL periodic_disabled: got busy=%0b done=%0b, want 0/1", busy2, done2);
                end
            end
            tick();
        end
        abort = 1;
        tick();
        abort = 0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (busy0 !== 1'b0 || done0 !== 1'b0) begin
                n_err++; $display("FAIL after_abort[%0d]: got busy=%0b done=%0b, want 0/0", k, busy0, done0);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        do_reset();
        start = 1; load = 6;
        tick();
        start = 0; load = 0;
        repeat (4) tick();
        hold = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (cnt0 !== 16'd2 || done0 !== 1'b0) begin
                n_err++; $display("FAIL hold_freeze[%0d]: got count=%0d done=%0b, want 2/0", k, cnt0, done0);
            end
        end
        hold = 0;
        tick();
        n_cmp++;
        if (cnt0 !== 16'd1 || done0 !== 1'b0) begin
            n_err++; $display("FAIL hold_resume: got count=%0d done=%0b, want 1/0", cnt0, done0);
        end
        tick();
        n_cmp++;
        if (cnt0 !== 16'd0 || done0 !== 1'b1) begin
            n_err++; $display("FAIL hold_done: got count=%0d done=%0b, want 0/1", cnt0, done0);
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        start = 1; load = 5;
        tick();
        start = 0; load = 0;
        repeat (3) tick();
        start = 1; load = 3;
        tick();
        start = 0; load = 0;
        n_cmp++;
        if (cnt0 !== 16'd1) begin
            n_err++; $display("FAIL noretrig_ignored: got count=%0d, want 1", cnt0);
        end
        n_cmp++;
        if (cnt1 !== 16'd3) begin
            n_err++; $display("FAIL retrig_reload: got count=%0d, want 3", cnt1);
        end
        tick();
        n_cmp++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || cnt1 !== 16'd2) begin
            n_err++; $display("FAIL retrig_suppress: got done0=%0b done1=%0b count1=%0d, want 1/0/2", done0, done1, cnt1);
        end
        tick();
        tick();
        n_cmp++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_err++; $display("FAIL retrig_done: got done=%0b busy=%0b, want 1/0", done1, busy1);
        end
    endtask

    task automatic test_bw4_reset();
        do_reset();
        start = 1; load = 15;
        tick();
        start = 0; load = 0;
        n_cmp++;
        if (cnt2 !== 4'd15 || busy2 !== 1'b1) begin
            n_err++; $display("FAIL bw4_load: got count=%0d busy=%0b, want 15/1", cnt2, busy2);
        end
        repeat (8) tick();
        n_cmp++;
        if (cnt2 !== 4'd7) begin
            n_err++; $display("FAIL bw4_mid: got count=%0d, want 7", cnt2);
        end
        rst = 1;
        tick();
        rst = 0;
        n_cmp++;
        if (cnt2 !== 4'd0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            n_err++; $display("FAIL bw4_reset: got count=%0d busy=%0b done=%0b, want 0/0/0", cnt2, busy2, done2);
        end
        start = 1; load = 3;
        tick();
        start = 0; load = 0;
        repeat (2) tick();
        n_cmp++;
        if (cnt2 !== 4'd1 || busy2 !== 1'b1) begin
            n_err++; $display("FAIL bw4_restart: got count=%0d busy=%0b, want 1/1", cnt2, busy2);
        end
        tick();
        n_cmp++;
        if (done2 !== 1'b1 || busy2 !== 1'b0) begin
            n_err++; $display("FAIL bw4_restart_done: got done=%0b busy=%0b, want 1/0", done2, busy2);
        end
    endtask

    // Reference model: remaining cycles, latched length, latched mode and
    // pending done flag, one entry per instance, updated from the rules.
    task automatic test_random();
        int  m_rem [3];
        int  m_len [3];
        bit  m_per [3];
        bit  m_done[3];
        bit  retrig[3]  = '{0, 1, 1};
        bit  per_en[3]  = '{1, 1, 0};
        int  modulus[3] = '{65536, 65536, 16};
        int  ld, act_c;
        bit  act_b, act_d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m_rem[i] = 0; m_len[i] = 0; m_per[i] = 0; m_done[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst      = ($urandom_range(0, 299) == 0);
            abort    = ($urandom_range(0, 39) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            start    = ($urandom_range(0, 5) == 0);
            periodic = $urandom_range(0, 1);
            load     = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 9));
            for (int i = 0; i < 3; i++) begin
                ld = int'(load) % modulus[i];
                if (rst) begin
                    m_rem[i] = 0; m_len[i] = 0; m_per[i] = 0; m_done[i] = 0;
                end else if (abort) begin
                    m_rem[i] = 0; m_per[i] = 0; m_done[i] = 0;
                end else if (start && ld != 0 && (m_rem[i] == 0 || retrig[i])) begin
                    m_rem[i] = ld; m_len[i] = ld; m_per[i] = periodic && per_en[i]; m_done[i] = 0;
                end else if (hold || m_rem[i] == 0) begin
                    m_done[i] = 0;
                end else if (m_rem[i] == 1) begin
                    m_done[i] = 1;
                    m_rem[i]  = m_per[i] ? m_len[i] : 0;
                end else begin
                    m_rem[i]  = m_rem[i] - 1;
                    m_done[i] = 0;
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                act_c = (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
                act_b = (i == 0) ? busy0 : (i == 1) ? busy1 : busy2;
                act_d = (i == 0) ? done0 : (i == 1) ? done1 : done2;
                n_cmp++;
                if (act_c !== m_rem[i] || act_b !== (m_rem[i] != 0) || act_d !== m_done[i]) begin
                    n_err++;
                    $display("FAIL random_dut%0d cyc %0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b",
                             i, cyc, act_c, act_b, act_d, m_rem[i], (m_rem[i] != 0), m_done[i]);
                end
            end
        end
        idle_inputs();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic();
        test_zero_load();
        test_periodic_abort();
        test_hold();
        test_retrigger();
        test_bw4_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/busyctr_prog.md
Name: busyctr_prog

Overview:
Programmable successor to the fixed-length busy counter. A start request loads a run-time length N. The block then reports busy for exactly N cycles, pulses done on expiry, and exposes the remaining count. Adds parametrised width, hold/pause, abort, optional retrigger and optional periodic auto-reload. Used as a generic timeout/hold-off timer by bus masters and peripheral controllers.

Parameters:
BW, 16, counter and load width in bits (2..32).
OPT_RETRIGGER, 1'b0, 1: a start while busy reloads the counter; 0: a start while busy is ignored.
OPT_PERIODIC, 1'b1, 1: i_periodic honoured; 0: i_periodic ignored, treated as 0.

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  start request, sampled every cycle
i_load  input  BW  length N, sampled with an accepted start
i_periodic  input  1  sampled with an accepted start; 1 = auto-reload on expiry
i_hold  input  1  freeze count while high
i_abort  input  1  cancel the current run
o_busy  output  1  counter != 0
o_done  output  1  single-cycle expiry pulse
o_count  output  BW  remaining cycles (current counter value)

Behaviour:
- Clock i_clk; reset i_reset, synchronous, active-high.
- State: counter[BW-1:0], r_len[BW-1:0] (latched N), r_per (latched periodic flag), r_done. All zero at initial and at reset.
- Reset values: o_busy=0, o_done=0, o_count=0.
- o_busy = (counter != 0), combinational from counter. o_count = counter. o_done = r_done, registered.
- Start accepted when: i_start && i_load != 0 && (counter == 0 || OPT_RETRIGGER).
- Start with i_load == 0 is ignored: no state change, no done.
- On accepted start: counter <= i_load; r_len <= i_load; r_per <= i_periodic && OPT_PERIODIC.
  - Start at cycle t gives o_busy high in cycles t+1 .. t+N (exactly N cycles).
- Decrement: counter <= counter - 1 when counter != 0, !i_hold, and no higher-priority event.
- Expiry: counter == 1 and decrementing.
  - r_done <= 1 for exactly one cycle, so o_done is high in the first cycle the counter reads 0, i.e. cycle t+N+1 for an unheld run.
  - If r_per: counter <= r_len instead of 0. o_busy stays high continuously. o_done pulses every r_len cycles.
  - With r_len == 1, o_done is high every cycle.
- Priority, highest first: i_reset > i_abort > accepted start > i_hold > decrement.
- i_abort: counter <= 0, r_per <= 0, r_done <= 0. No done pulse. Abort while idle is a no-op.
- Retrigger (OPT_RETRIGGER=1, busy): counter reloads to i_load, mode re-latched, no done pulse for the cancelled run. This applies even in the expiry cycle: start wins, no done.
- Retrigger disabled, busy: start ignored, including in the expiry cycle.
  - Start in the cycle where counter == 0 (including the o_done cycle) is accepted.
- i_hold: counter, r_len, r_per frozen; r_done <= 0.
  - Hold while counter == 1 delays expiry; done fires one cycle after hold drops.
  - Start while idle is accepted even with i_hold high.
  - Start while busy under hold follows the retrigger rules.
- Width: arithmetic modulo 2^BW, but the counter never wraps: decrement only when nonzero. Max run length is 2^BW-1.
- Reset mid-run clears everything within one cycle; no done pulse.
- Formal intent:
  - o_busy == (counter != 0).
  - o_done implies the previous counter == 1.
  - With i_start never accepted, counter stays 0.
  - counter <= r_len whenever busy.

Test Plan:
- BW=16, idle, i_start=1 with i_load=5 at cycle 10 -> o_busy high cycles 11-15, o_count 5,4,3,2,1, o_done high cycle 16 only.
- i_load=0 with i_start -> o_busy stays 0, no o_done. Then i_load=1 -> o_busy for 1 cycle, o_done next cycle.
- i_load=4, i_periodic=1 -> o_busy continuously high, o_done every 4 cycles. i_abort -> o_busy low next cycle, no further o_done.
- i_load=6, i_hold high for 3 cycles when o_count=2 -> count freezes at 2. o_done arrives 3 cycles later than the unheld run.
- OPT_RETRIGGER=0: i_start(i_load=3) at o_count=2 ignored, done on schedule. OPT_RETRIGGER=1: same stimulus -> o_count 3 next cycle, original done suppressed.
- BW=4, i_load=15, i_reset asserted at o_count=7 -> next cycle o_count=0, o_busy=0, o_done=0. Restart works normally.
